mem_line_responder: RTL and testbench
=====================================

Name: mem_line_responder

Overview:
- Memory-side responder for the cache's 128-bit line interface; plays the memory role opposite the cache's request/ready handshake.
- Accepts line read/write requests (level-held by the requester until mem_ready).
- Holds a line-wide storage array and returns mem_ready after a fixed, parameterised latency.
- Used as the synthesizable slow-memory model in the CPU testbench and FPGA build; also counts completed transactions for performance reporting.

Parameters:
- LATENCY, 4: cycles from request acceptance to mem_ready; legal range 2..255.
- ADDR_W, 8: index bits used from mem_addr; storage holds 2^ADDR_W lines of 128 bits.

Ports:
- clk  input  1  clock
- proc_reset  input  1  asynchronous, active-high reset
- mem_read  input  1  line read request, held high until mem_ready is seen
- mem_write  input  1  line write request, held high until mem_ready is seen
- mem_addr  input  28  line address; only [ADDR_W-1:0] used, upper bits ignored (aliasing)
- mem_wdata  input  128  write line data
- mem_rdata  output  128  read line data, registered
- mem_ready  output  1  one-cycle completion pulse, registered
- rd_done_cnt  output  16  completed reads, saturating
- wr_done_cnt  output  16  completed writes, saturating

Behaviour:
- Reset (async, any state): state=IDLE, mem_ready=0, mem_rdata=0, counters=0, latency counter=0, latched op cleared. Storage array contents are not reset. A pending write is discarded and never committed.
- Request present = mem_read | mem_write.
- States: IDLE, WAIT, DONE.
- IDLE:
  - If a request is present in cycle t0, latch op: write if mem_write=1, else read. Write has priority when both are high.
  - Load cnt=LATENCY-1 and go to WAIT.
  - With no request, stay in IDLE.
- WAIT:
  - If no request is present in any cycle, abort: go to IDLE with no mem_ready, no array write, no counter update, and mem_rdata unchanged.
  - Else if cnt>1, decrement and stay.
  - Else (cnt==1, i.e. cycle t0+LATENCY-1), perform the access at the closing edge using the mem_addr and mem_wdata present in that cycle:
    - Read: mem_rdata <= array[idx].
    - Write: array[idx] <= mem_wdata; mem_rdata unchanged.
  - Then set mem_ready <= 1, increment the matching counter (saturate at 16'hFFFF), and go to DONE.
- Address and data are sampled only in the final WAIT cycle. Earlier cycles may carry stale addresses: the requester's address register settles one cycle after the request rises.
- DONE:
  - mem_ready=1 for exactly this cycle (cycle t0+LATENCY); mem_rdata is valid here.
  - The request is still high this cycle and is ignored.
  - Next state IDLE; mem_ready returns to 0.
- A new request high in the cycle after DONE is accepted as a new t0. This supports back-to-back write-back then allocate, with a minimum 1 idle cycle between transactions.
- Latency: request first high in cycle t0 → mem_ready high in cycle t0+LATENCY, exactly.
- mem_rdata holds its value until the next completed read.
- A read of an index never written returns undefined storage contents; benches must write before reading.

Test Plan:
- LATENCY=4. Write addr 28'h0000005, data 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, request rising at t0 → mem_ready high only in cycle t0+4; wr_done_cnt=1. Then read addr 5 → mem_ready at t0'+4 and mem_rdata equals the written line in that cycle; rd_done_cnt=1.
- Back-to-back: write to addr 3 completes, mem_read rises the next cycle with addr 7 valid from the following cycle → second mem_ready exactly 4 cycles after the read request rises; mem_rdata=array[7]; no spurious extra mem_ready pulses.
- Stale address: request rises with mem_addr=9, changes to 2 in cycle t0+1 → access uses index 2.
- Abort: mem_write high for 2 cycles, then both requests low → no mem_ready; array[idx] unchanged on read-back; wr_done_cnt unchanged.
- Reset mid-WAIT: assert proc_reset during t0+2 of a write → mem_ready=0 immediately, counters 0, state IDLE, target line not overwritten.
- Simultaneous mem_read=mem_write=1 on addr 1 → treated as write: array[1]=mem_wdata, wr_done_cnt increments, rd_done_cnt unchanged. Separately, preload rd_done_cnt near saturation via 65535 reads (or a forced value) → the count stays at 16'hFFFF after further reads.

Source files
------------

// File: rtl/mem_line_responder_if.sv
// mem_line_responder_if: 128-bit line request/ready handshake between cache and memory
interface mem_line_responder_if;
  logic mem_read;
  logic mem_write;
  logic [27:0] mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic mem_ready;
  modport master (output mem_read, mem_write, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave (input mem_read, mem_write, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/mem_line_responder.sv
// mem_line_responder: fixed-latency line memory with completed-transaction counters
module mem_line_responder #(
  parameter int LATENCY = 4,
  parameter int ADDR_W = 8
) (
  input logic clk,
  input logic proc_reset,
  mem_line_responder_if.slave bus,
  output logic [15:0] rd_done_cnt,
  output logic [15:0] wr_done_cnt
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state;
  logic [7:0] cnt;
  logic op_wr;
  logic [127:0] mem [2**ADDR_W];
  logic req;
  logic fire;
  logic [ADDR_W-1:0] idx;
  logic unused_addr;
  assign req = bus.mem_read | bus.mem_write;
  assign fire = state == WAIT && req && cnt == 8'd1;
  assign idx = bus.mem_addr[ADDR_W-1:0];
  assign unused_addr = ^bus.mem_addr[27:ADDR_W];
  // Storage is never reset; a write commits only on the final wait cycle, so reset drops it.
  always_ff @(posedge clk)
    if (fire && op_wr && !proc_reset) mem[idx] <= bus.mem_wdata;
  // Request FSM: latch op, count down the latency, then pulse ready for one cycle.
  always_ff @(posedge clk or posedge proc_reset)
    if (proc_reset) begin
      state <= IDLE;
      cnt <= '0;
      op_wr <= 1'b0;
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
      rd_done_cnt <= '0;
      wr_done_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          op_wr <= bus.mem_write;
          cnt <= 8'(LATENCY - 1);
          state <= WAIT;
        end
        WAIT: if (!req) state <= IDLE;
        else if (cnt > 8'd1) cnt <= cnt - 8'd1;
        else begin
          if (!op_wr) bus.mem_rdata <= mem[idx];
          if (!op_wr && rd_done_cnt != 16'hFFFF) rd_done_cnt <= rd_done_cnt + 16'd1;
          if (op_wr && wr_done_cnt != 16'hFFFF) wr_done_cnt <= wr_done_cnt + 16'd1;
          bus.mem_ready <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          bus.mem_ready <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_line_responder.sv
// tb_mem_line_responder: directed checks of latency, data, abort, reset and counters
module tb_mem_line_responder;
  logic clk = 0;
  logic proc_reset = 1;
  logic [15:0] rd_done_cnt, wr_done_cnt;
  int n_cmp = 0;
  int n_err = 0;
  int lat;
  int exp_rd = 0;
  int exp_wr = 0;
  localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] D3 = 128'h3333_0000_3333_0000_3333_0000_3333_0003;
  localparam logic [127:0] D7 = 128'h7777_7777_0000_0000_7777_7777_0000_0007;
  localparam logic [127:0] D9 = 128'h9999_AAAA_9999_AAAA_9999_AAAA_9999_0009;
  localparam logic [127:0] D2 = 128'h2222_BBBB_2222_BBBB_2222_BBBB_2222_0002;
  localparam logic [127:0] DX = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [127:0] DB = 128'hB0B0_1111_B0B0_1111_B0B0_1111_B0B0_0001;
  mem_line_responder_if bus ();
  mem_line_responder #(.LATENCY(4), .ADDR_W(8)) dut (
    .clk(clk),
    .proc_reset(proc_reset),
    .bus(bus),
    .rd_done_cnt(rd_done_cnt),
    .wr_done_cnt(wr_done_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic xact(input logic rd, input logic wr, input logic [27:0] a0, input logic [27:0] a1,
                      input logic [127:0] wd, output int l);
    bus.mem_read = rd;
    bus.mem_write = wr;
    bus.mem_addr = a0;
    bus.mem_wdata = wd;
    l = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.mem_ready) begin
        l = i;
        break;
      end
      if (i == 1) bus.mem_addr = a1;
    end
    bus.mem_read = 0;
    bus.mem_write = 0;
    if (l > 0) begin
      @(negedge clk);
      chk("no_extra_ready", 128'(bus.mem_ready), 128'(0));
    end
  endtask
  initial begin
    bus.mem_read = 0;
    bus.mem_write = 0;
    bus.mem_addr = '0;
    bus.mem_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 128'(bus.mem_ready), 128'(0));
    chk("rst_rdata", bus.mem_rdata, 128'(0));
    chk("rst_rd_cnt", 128'(rd_done_cnt), 128'(0));
    chk("rst_wr_cnt", 128'(wr_done_cnt), 128'(0));
    proc_reset = 0;
    @(negedge clk);
    xact(0, 1, 28'h0000005, 28'h0000005, D1, lat);
    exp_wr++;
    chk("wr5_lat", 128'(lat), 128'(4));
    chk("wr5_cnt", 128'(wr_done_cnt), 128'(exp_wr));
    xact(1, 0, 28'h0000005, 28'h0000005, '0, lat);
    exp_rd++;
    chk("rd5_lat", 128'(lat), 128'(4));
    chk("rd5_data", bus.mem_rdata, D1);
    chk("rd5_cnt", 128'(rd_done_cnt), 128'(exp_rd));
    xact(0, 1, 28'h7, 28'h7, D7, lat);
    exp_wr++;
    xact(0, 1, 28'h3, 28'h3, D3, lat);
    exp_wr++;
    chk("b2b_wr_lat", 128'(lat), 128'(4));
    xact(1, 0, 28'h3, 28'h7, '0, lat);
    exp_rd++;
    chk("b2b_rd_lat", 128'(lat), 128'(4));
    chk("b2b_rd_data", bus.mem_rdata, D7);
    chk("b2b_wr_cnt", 128'(wr_done_cnt), 128'(exp_wr));
    xact(0, 1, 28'h9, 28'h9, D9, lat);
    exp_wr++;
    xact(0, 1, 28'h9, 28'h2, D2, lat);
    exp_wr++;
    chk("stale_lat", 128'(lat), 128'(4));
    xact(1, 0, 28'h9, 28'h9, '0, lat);
    exp_rd++;
    chk("stale_rd9", bus.mem_rdata, D9);
    xact(1, 0, 28'h2, 28'h2, '0, lat);
    exp_rd++;
    chk("stale_rd2", bus.mem_rdata, D2);
    xact(1, 0, 28'hABCDE05, 28'hABCDE05, '0, lat);
    exp_rd++;
    chk("alias_rd5", bus.mem_rdata, D1);
    bus.mem_write = 1;
    bus.mem_addr = 28'h5;
    bus.mem_wdata = DX;
    repeat (2) @(negedge clk);
    bus.mem_write = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_no_ready", 128'(bus.mem_ready), 128'(0));
    end
    chk("abort_wr_cnt", 128'(wr_done_cnt), 128'(exp_wr));
    chk("abort_rdata_held", bus.mem_rdata, D1);
    xact(1, 0, 28'h5, 28'h5, '0, lat);
    exp_rd++;
    chk("abort_rd5", bus.mem_rdata, D1);
    chk("abort_rd_cnt", 128'(rd_done_cnt), 128'(exp_rd));
    bus.mem_write = 1;
    bus.mem_addr = 28'h5;
    bus.mem_wdata = DX;
    repeat (2) @(negedge clk);
    proc_reset = 1;
    bus.mem_write = 0;
    #1;
    chk("midrst_ready", 128'(bus.mem_ready), 128'(0));
    chk("midrst_wr_cnt", 128'(wr_done_cnt), 128'(0));
    chk("midrst_rd_cnt", 128'(rd_done_cnt), 128'(0));
    chk("midrst_rdata", bus.mem_rdata, 128'(0));
    @(negedge clk);
    proc_reset = 0;
    exp_rd = 0;
    exp_wr = 0;
    repeat (2) @(negedge clk);
    xact(1, 0, 28'h5, 28'h5, '0, lat);
    exp_rd++;
    chk("midrst_lat", 128'(lat), 128'(4));
    chk("midrst_rd5", bus.mem_rdata, D1);
    xact(1, 1, 28'h1, 28'h1, DB, lat);
    exp_wr++;
    chk("both_wr_cnt", 128'(wr_done_cnt), 128'(exp_wr));
    chk("both_rd_cnt", 128'(rd_done_cnt), 128'(exp_rd));
    chk("both_rdata_held", bus.mem_rdata, D1);
    xact(1, 0, 28'h1, 28'h1, '0, lat);
    chk("both_rd1", bus.mem_rdata, DB);
    force dut.rd_done_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.rd_done_cnt;
    @(negedge clk);
    chk("sat_preload", 128'(rd_done_cnt), 128'(16'hFFFE));
    xact(1, 0, 28'h1, 28'h1, '0, lat);
    chk("sat_ffff", 128'(rd_done_cnt), 128'(16'hFFFF));
    xact(1, 0, 28'h1, 28'h1, '0, lat);
    chk("sat_hold", 128'(rd_done_cnt), 128'(16'hFFFF));
    chk("sat_lat", 128'(lat), 128'(4));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
